// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: accepts one word access at a time, inserts
// WAIT_STATES wait cycles, then returns a single-cycle response pulse.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall_out
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  lat_we;
    logic [AW-1:0]         lat_addr;
    logic [DW-1:0]         lat_wdata;
    logic [DW-1:0]         mem [DEPTH];

    logic                  accept;
    logic                  lat_oor;
    logic [DEPTH_LOG2-1:0] lat_idx;

    assign accept    = req_valid && req_ready;
    assign lat_oor   = (lat_addr >> DEPTH_LOG2) != '0;
    assign lat_idx   = lat_addr[DEPTH_LOG2-1:0];
    assign stall_out = req_valid && !req_ready;

    // The RESP cycle computes the result; the response registers and the
    // array write both land on the edge that ends RESP, so a request accepted
    // on that same edge observes the committed write.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rsp_valid <= 1'b0;

            case (state)
                ST_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= ST_RESP;
                        req_ready <= 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= lat_oor;
                    rsp_rdata <= (lat_we || lat_oor) ? '0 : mem[lat_idx];
                    if (lat_we && !lat_oor) begin
                        mem[lat_idx] <= lat_wdata;
                    end
                    if (!req_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: ;
            endcase

            // Acceptance from IDLE or RESP; overrides the RESP->IDLE decision.
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= CW'(WAIT_STATES);
                if (WAIT_STATES != 0) begin
                    state     <= ST_WAIT;
                    req_ready <= 1'b0;
                end else begin
                    state     <= ST_RESP;
                    req_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, giving the log2 of the word-array depth (256 x 16-bit words).
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, giving the wait cycles inserted per access (legal 0..15).
REQ-003 The block SHALL have a single clock; reset SHALL be synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: synchronous reset, active-high (1 = reset asserted), sampled on the clk rising edge.
REQ-006 The block SHALL have port req_valid, input, 1 bit: memory-access stage presents a request.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, 16 bits: word address.
REQ-009 The block SHALL have port req_wdata, input, 16 bits: store data.
REQ-010 The block SHALL have port req_ready, output, 1 bit: responder can accept a request this cycle.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: response valid, one-cycle pulse.
REQ-012 The block SHALL have port rsp_rdata, output, 16 bits: read data.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: accessed address out of range.
REQ-014 The block SHALL have port stall_out, output, 1 bit: pipeline hold request, equal to req_valid & ~req_ready.

Function
REQ-015 The FSM SHALL have three states, IDLE, WAIT and RESP; req_ready SHALL be 1 in IDLE and RESP and 0 in WAIT.
REQ-016 Acceptance SHALL occur on any edge where req_valid & req_ready: latch req_we/req_addr/req_wdata and load a 4-bit wait counter with WAIT_STATES.
REQ-017 On acceptance, the next state SHALL be WAIT if WAIT_STATES > 0, else RESP.
REQ-018 In WAIT, the counter SHALL decrement every cycle; on the edge where counter == 1, the FSM SHALL go to RESP, so exactly WAIT_STATES cycles are spent in WAIT.
REQ-019 Latency: for a request accepted at edge k, rsp_valid SHALL be high for exactly the one cycle after edge k+1+WAIT_STATES (immediately after edge k+1 when WAIT_STATES = 0).
REQ-020 rsp_valid SHALL be asserted only in RESP; outside RESP, rsp_valid = 0 and rsp_rdata and rsp_err hold their last values.
REQ-021 A read in range SHALL give rsp_rdata = array[latched addr] at the RESP cycle; a write SHALL give rsp_rdata = 16'h0000.
REQ-022 A write in range SHALL update the array on the edge that ends the RESP cycle.
REQ-023 Range check: if latched addr[15:DEPTH_LOG2] != 0, rsp_err SHALL be 1 in RESP, no array write SHALL occur, and rsp_rdata SHALL be 16'h0000; otherwise rsp_err = 0.
REQ-024 In RESP with req_valid = 1, the new request SHALL be accepted on the same edge as the old write commit (back-to-back); peak throughput SHALL be one access per WAIT_STATES+1 cycles.
REQ-025 In RESP with req_valid = 0, the next state SHALL be IDLE.
REQ-026 Read-after-write to the same address, including back-to-back, SHALL return the newly written data.
REQ-027 No combinational path SHALL exist from req_* inputs to rsp_* outputs; stall_out is the only combinational output.

Reset
REQ-028 With reset_n = 1 at an edge, the block SHALL set state IDLE, counter 0, rsp_valid 0, rsp_rdata 16'h0000, rsp_err 0, and all array words 16'h0000.
REQ-029 Reset mid-operation (WAIT or RESP) SHALL discard the pending access: no array write, no rsp_valid pulse.
REQ-030 Reset SHALL take priority over a simultaneous acceptance.

Verification
REQ-031 Reset then read addr 0x0005 -> rsp_valid pulses 3 cycles after the accept edge (WAIT_STATES=2), rsp_rdata=0x0000, rsp_err=0.
REQ-032 Write 0x00A3 <- 0xBEEF, then immediate back-to-back read 0x00A3 -> read response 0xBEEF; stall_out=1 during the 2 WAIT cycles of each access.
REQ-033 Write 0x0100 <- 0x1234 -> rsp_err=1, rsp_rdata=0x0000; a later read of 0x0000 returns 0x0000 (no aliasing).
REQ-034 WAIT_STATES=0 with req_valid held high for 4 writes -> one rsp_valid per cycle, req_ready constantly 1.
REQ-035 Write 0x0010 <- 0x5555 with reset asserted during WAIT -> no rsp_valid; a subsequent read of 0x0010 returns 0x0000.
REQ-036 req_valid=0 for 10 cycles -> state IDLE, req_ready=1, rsp_valid=0, stall_out=0 throughout.
